// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the uart_ctrl transmit write port between NREQ byte streams.
// Grant is one cycle after request; bytes are accepted combinationally and stall while isfull is high.
module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int MAXLEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    data,
  input  logic [NREQ-1:0]      last,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      gnt,
  output logic                 write,
  output logic [7:0]           wrdata,
  input  logic                 isfull,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr;
  logic [7:0]    cnt;

  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic [IW-1:0] g_inc;
  logic          found;
  logic          xfer;
  logic          release_g;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign xfer      = (state == GRANT) & req[g] & ~isfull;
  assign release_g = (state == GRANT) &
                     (~req[g] | (xfer & (last[g] | (cnt == 8'(MAXLEN - 1)))));
  assign g_inc     = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;

  assign write  = xfer;
  assign ack    = xfer ? (NREQ'(1) << g) : '0;
  assign wrdata = xfer ? data[{g, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      cnt   <= 8'd0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && found) begin
            state <= GRANT;
            g     <= win;
            gnt   <= NREQ'(1) << win;
            busy  <= 1'b1;
            cnt   <= 8'd0;
          end
        end
        GRANT: begin
          // Release always passes through IDLE, giving the one-cycle arbitration bubble.
          if (release_g) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= g_inc;
          end else if (xfer) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
